// File: rtl/micro_core_param.sv
// Parametrised micro core: fetch/execute FSM with PC, imem handshake,
// register file, data memory, compare flags, carry and HALT.
module micro_core_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NREG       = 4,
  parameter int unsigned DMEM_DEPTH = 16,
  parameter int unsigned PC_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req_o,
  output logic [PC_W-1:0]         imem_addr_o,
  input  logic                    imem_valid_i,
  input  logic [15:0]             imem_data_i,
  output logic [PC_W-1:0]         pc_o,
  output logic                    halted_o,
  output logic [2:0]              flag_cmp_o,
  output logic                    carry_o,
  input  logic [$clog2(NREG)-1:0] dbg_sel_i,
  output logic [DATA_W-1:0]       dbg_data_o
);

  localparam int unsigned RIDX_W = $clog2(NREG);
  localparam int unsigned AW     = $clog2(DMEM_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [2:0]        flag_q, flag_d;
  logic              carry_q, carry_d;
  logic              imem_req_q;
  logic              halted_q;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];

  // Instruction field decode
  logic [3:0]        op, rd_f, rs_f;
  logic [7:0]        imm;
  logic              rd_ok, rs_ok;
  logic [RIDX_W-1:0] rd_idx, rs_idx;
  logic [AW-1:0]     dm_addr;
  logic [DATA_W-1:0] rd_val, rs_val, simm, zimm;

  assign op      = ir_q[15:12];
  assign rd_f    = ir_q[11:8];
  assign rs_f    = ir_q[7:4];
  assign imm     = ir_q[7:0];
  // Register fields wider than the file are illegal, not aliased
  assign rd_ok   = (rd_f >> RIDX_W) == 4'd0;
  assign rs_ok   = (rs_f >> RIDX_W) == 4'd0;
  assign rd_idx  = rd_f[RIDX_W-1:0];
  assign rs_idx  = rs_f[RIDX_W-1:0];
  assign dm_addr = imm[AW-1:0];
  assign rd_val  = rd_ok ? regs_q[rd_idx] : '0;
  assign rs_val  = rs_ok ? regs_q[rs_idx] : '0;
  assign simm    = DATA_W'($signed(imm));
  assign zimm    = DATA_W'(imm);

  logic              rf_we, dm_we, taken;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W:0]   add_res;

  // Next-state, execute and commit-control logic
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    flag_d   = flag_q;
    carry_d  = carry_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    dm_we    = 1'b0;
    taken    = 1'b0;
    add_res  = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_valid_i) begin
          ir_d    = imem_data_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + PC_W'(1);
        case (op)
          4'h1: begin rf_we = rd_ok; rf_wdata = dmem_q[dm_addr]; end
          4'h2: dm_we = 1'b1;
          4'h3: begin rf_we = rd_ok; rf_wdata = rs_val; end
          4'h4: begin rf_we = rd_ok; rf_wdata = simm; end
          4'h5, 4'hA: begin
            add_res  = {1'b0, rd_val} + {1'b0, (op == 4'hA) ? simm : rs_val};
            rf_we    = rd_ok;
            rf_wdata = add_res[DATA_W-1:0];
            carry_d  = add_res[DATA_W];
          end
          4'h6: begin
            rf_we    = rd_ok;
            rf_wdata = rd_val - rs_val;
            carry_d  = rd_val < rs_val;
          end
          4'h7: begin rf_we = rd_ok; rf_wdata = rd_val & rs_val; end
          4'h8: begin rf_we = rd_ok; rf_wdata = rd_val | rs_val; end
          4'h9: begin rf_we = rd_ok; rf_wdata = rd_val ^ rs_val; end
          4'hB: flag_d = {rd_val > rs_val, rd_val == rs_val, rd_val < rs_val};
          4'hC: flag_d = {rd_val > zimm, rd_val == zimm, rd_val < zimm};
          4'hD: pc_d = imm[PC_W-1:0];
          4'hE: begin
            case (rd_f)
              4'd0:    taken = flag_q[1];
              4'd1:    taken = flag_q[0];
              4'd2:    taken = flag_q[2];
              4'd3:    taken = carry_q;
              default: taken = 1'b0;
            endcase
            if (taken) pc_d = imm[PC_W-1:0];
          end
          4'hF: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: ;
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Control/status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ir_q       <= '0;
      pc_q       <= '0;
      flag_q     <= '0;
      carry_q    <= 1'b0;
      imem_req_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      flag_q     <= flag_d;
      carry_q    <= carry_d;
      imem_req_q <= (state_d == S_FETCH);
      halted_q   <= (state_d == S_HALT);
    end
  end

  // Register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rd_idx] <= rf_wdata;
    end
  end

  // Data memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
    end else if (dm_we) begin
      dmem_q[dm_addr] <= rd_val;
    end
  end

  assign imem_req_o  = imem_req_q;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign halted_o    = halted_q;
  assign flag_cmp_o  = flag_q;
  assign carry_o     = carry_q;
  assign dbg_data_o  = regs_q[dbg_sel_i];

endmodule

// File: tb/tb_micro_core_param.sv
// Directed bench for micro_core_param with an expectation queue.
module tb_micro_core_param;

  logic        clk;
  logic        rst;
  logic        imem_req_o;
  logic [7:0]  imem_addr_o;
  logic        imem_valid_i;
  logic [15:0] imem_data_i;
  logic [7:0]  pc_o;
  logic        halted_o;
  logic [2:0]  flag_cmp_o;
  logic        carry_o;
  logic [1:0]  dbg_sel_i;
  logic [7:0]  dbg_data_o;

  micro_core_param dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_valid_i (imem_valid_i),
    .imem_data_i  (imem_data_i),
    .pc_o         (pc_o),
    .halted_o     (halted_o),
    .flag_cmp_o   (flag_cmp_o),
    .carry_o      (carry_o),
    .dbg_sel_i    (dbg_sel_i),
    .dbg_data_o   (dbg_data_o)
  );

  localparam int K_PC = 0, K_REQ = 1, K_ADDR = 2, K_HALT = 3,
                 K_FLAG = 4, K_CARRY = 5, K_REG = 6;

  typedef struct {
    logic [127:0] tag;
    int           kind;
    int           sel;
    logic [31:0]  exp;
  } chk_t;

  chk_t sb[$];
  int   checks = 0;
  int   passed = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic sb_push(input logic [127:0] tag, input int kind, input int sel,
                         input logic [31:0] v);
    chk_t e;
    e.tag = tag; e.kind = kind; e.sel = sel; e.exp = v;
    sb.push_back(e);
  endtask

  // Pop every queued expectation and compare with the DUT output now
  task automatic drain();
    chk_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_PC:    obs = 32'(pc_o);
        K_REQ:   obs = 32'(imem_req_o);
        K_ADDR:  obs = 32'(imem_addr_o);
        K_HALT:  obs = 32'(halted_o);
        K_FLAG:  obs = 32'(flag_cmp_o);
        K_CARRY: obs = 32'(carry_o);
        default: begin
          dbg_sel_i = 2'(e.sel);
          #1;
          obs = 32'(dbg_data_o);
        end
      endcase
      checks++;
      assert (obs === e.exp) passed++;
      else $error("FAIL %0s: observed %0h expected %0h", e.tag, obs, e.exp);
    end
  endtask

  // Serve one instruction on the fetch handshake, return after its EXEC edge
  task automatic exec_instr(input logic [15:0] instr);
    int n = 0;
    while (imem_req_o !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (imem_req_o === 1'b1) passed++;
    else $error("FAIL fetch_req: observed %b expected 1", imem_req_o);
    imem_valid_i = 1'b1;
    imem_data_i  = instr;
    @(negedge clk);
    imem_valid_i = 1'b0;
    imem_data_i  = 16'h0;
    @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    imem_valid_i = 1'b0;
    imem_data_i  = 16'h0;
    dbg_sel_i    = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state: IDLE one cycle, then fetch from 0
    sb_push("rst_pc", K_PC, 0, 0);
    sb_push("rst_req", K_REQ, 0, 0);
    sb_push("rst_halt", K_HALT, 0, 0);
    sb_push("rst_flag", K_FLAG, 0, 0);
    sb_push("rst_carry", K_CARRY, 0, 0);
    sb_push("rst_r1", K_REG, 1, 0);
    drain();
    @(negedge clk);
    sb_push("idle_req", K_REQ, 0, 1);
    sb_push("idle_addr", K_ADDR, 0, 0);
    drain();

    // MVI r1,0x7F; ADDI r1,1; ADD r1,r1
    exec_instr(16'h417F);
    exec_instr(16'hA101);
    sb_push("addi_r1", K_REG, 1, 32'h80);
    sb_push("addi_carry", K_CARRY, 0, 0);
    drain();
    exec_instr(16'h5110);
    sb_push("add_r1", K_REG, 1, 32'h00);
    sb_push("add_carry", K_CARRY, 0, 1);
    sb_push("add_pc", K_PC, 0, 3);
    drain();

    // MVI r2,0xA5; ST r2,[F]; MVI r2,0; LD r3,[0x1F aliases F]
    exec_instr(16'h42A5);
    exec_instr(16'h220F);
    exec_instr(16'h4200);
    exec_instr(16'h131F);
    sb_push("ld_r3", K_REG, 3, 32'hA5);
    sb_push("mvi_r2", K_REG, 2, 32'h00);
    sb_push("ldst_pc", K_PC, 0, 7);
    drain();

    // Reset asserted while a fetch is being answered
    imem_valid_i = 1'b1;
    imem_data_i  = 16'h4311;
    #2 rst = 1'b1;
    @(negedge clk);
    imem_valid_i = 1'b0;
    imem_data_i  = 16'h0;
    rst = 1'b0;
    #1;
    sb_push("mrst_pc", K_PC, 0, 0);
    sb_push("mrst_req", K_REQ, 0, 0);
    sb_push("mrst_halt", K_HALT, 0, 0);
    sb_push("mrst_flag", K_FLAG, 0, 0);
    sb_push("mrst_carry", K_CARRY, 0, 0);
    sb_push("mrst_r3", K_REG, 3, 0);
    drain();
    @(negedge clk);
    sb_push("mrst_req1", K_REQ, 0, 1);
    sb_push("mrst_addr", K_ADDR, 0, 0);
    drain();

    // r0=3, r1=5; CMP; BCC lt taken; BCC eq not taken; CMPI eq; SUB borrow
    exec_instr(16'h4003);
    exec_instr(16'h4105);
    exec_instr(16'hB010);
    sb_push("cmp_flag", K_FLAG, 0, 3'b001);
    sb_push("cmp_pc", K_PC, 0, 3);
    drain();
    exec_instr(16'hE120);
    sb_push("bcc_lt_pc", K_PC, 0, 32'h20);
    drain();
    exec_instr(16'hE040);
    sb_push("bcc_eq_pc", K_PC, 0, 32'h21);
    sb_push("bcc_flag", K_FLAG, 0, 3'b001);
    drain();
    exec_instr(16'hC105);
    sb_push("cmpi_flag", K_FLAG, 0, 3'b010);
    sb_push("cmpi_pc", K_PC, 0, 32'h22);
    drain();
    exec_instr(16'h6010);
    sb_push("sub_r0", K_REG, 0, 32'hFE);
    sb_push("sub_carry", K_CARRY, 0, 1);
    sb_push("sub_pc", K_PC, 0, 32'h23);
    drain();

    // Fetch stalled with imem_valid low for 3 cycles
    for (int i = 0; i < 3; i++) begin
      sb_push("stall_req", K_REQ, 0, 1);
      sb_push("stall_addr", K_ADDR, 0, 32'h23);
      sb_push("stall_r0", K_REG, 0, 32'hFE);
      drain();
      @(negedge clk);
    end

    // JMP 0xFF then NOP wraps pc to 0
    exec_instr(16'hD0FF);
    sb_push("jmp_pc", K_PC, 0, 32'hFF);
    drain();
    exec_instr(16'h0000);
    sb_push("wrap_pc", K_PC, 0, 0);
    drain();

    // Illegal register indices: MOV from r9 reads 0, MVI to r6 dropped
    exec_instr(16'h4233);
    sb_push("mvi_r2_33", K_REG, 2, 32'h33);
    drain();
    exec_instr(16'h3290);
    sb_push("mov_ill_rs", K_REG, 2, 0);
    drain();
    exec_instr(16'h4612);
    sb_push("mvi_ill_rd", K_REG, 2, 0);
    drain();

    // NOP to pc=4, then HALT
    exec_instr(16'h0000);
    exec_instr(16'hF000);
    sb_push("halt_flag", K_HALT, 0, 1);
    sb_push("halt_req", K_REQ, 0, 0);
    sb_push("halt_pc", K_PC, 0, 4);
    drain();
    imem_valid_i = 1'b1;
    imem_data_i  = 16'h4177;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sb_push("hold_halt", K_HALT, 0, 1);
      sb_push("hold_req", K_REQ, 0, 0);
      sb_push("hold_pc", K_PC, 0, 4);
      drain();
    end
    sb_push("hold_r1", K_REG, 1, 5);
    drain();
    imem_valid_i = 1'b0;
    imem_data_i  = 16'h0;

    // Reset leaves HALT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    sb_push("unhalt", K_HALT, 0, 0);
    sb_push("unhalt_pc", K_PC, 0, 0);
    sb_push("unhalt_req", K_REQ, 0, 0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
